// File: rtl/c4_stim_if.sv
// Handshake/data bundle between a run controller and the c4_stim serial source.
interface c4_stim_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(W + 1)
);
  logic          start;
  logic [W-1:0]  pat;
  logic [CW-1:0] len;
  logic          lfsr;
  logic          stop;
  logic          a;
  logic          busy;
  logic          done;

  modport master (output start, pat, len, lfsr, stop, input a, busy, done);
  modport slave  (input start, pat, len, lfsr, stop, output a, busy, done);
endinterface

// File: rtl/c4_stim.sv
// Serial stimulus source for c4: plays a captured pattern (shift) or an LFSR
// sequence MSB first, one bit per falling edge of n_clk.
module c4_stim #(
  parameter int unsigned   W    = 8,
  parameter int unsigned   CW   = $clog2(W + 1),
  parameter logic [W-1:0]  TAPS = W'(8'hB8)
) (
  input  logic       n_clk,
  input  logic       rst,
  c4_stim_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          m_q, m_d;
  logic          a_q, a_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [CW-1:0] eff_len;
  logic [W-1:0]  seed;
  logic [W-1:0]  sh_next;

  // Capture-time length clamp (shift mode only) and zero-seed substitution (LFSR mode only)
  always_comb begin
    eff_len = bus.len;
    if (!bus.lfsr && (bus.len > CW'(W))) eff_len = CW'(W);
    seed = bus.pat;
    if (bus.lfsr && (bus.pat == '0)) seed = W'(1);
  end

  // Next shift-register value for the captured mode
  always_comb begin
    if (m_q) sh_next = {sh_q[W-2:0], ^(sh_q & TAPS)};
    else     sh_next = {sh_q[W-2:0], 1'b0};
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    a_d     = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sh_d = seed;
          m_d  = bus.lfsr;
          if (eff_len == '0) begin
            cnt_d   = '0;
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d   = eff_len - CW'(1);
            state_d = RUN;
            a_d     = seed[W-1];
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          sh_d    = sh_next;
          cnt_d   = cnt_q - CW'(1);
          a_d     = sh_next[W-1];
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers on the falling edge, async reset
  always_ff @(negedge n_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      m_q     <= 1'b0;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.a    = a_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/c4_stim.md
# c4_stim

Serial stimulus source that sits directly upstream of the `c4` state machine and drives its `a` input. It captures a pattern on a `start` request and plays it out one bit per clock, MSB first. It has two modes: plain shift, or a Fibonacci LFSR for long pseudo-random runs. `busy` and `done` let a controller or bench sequence successive runs without counting cycles.

## Interface
- `W`, 8, pattern/shift-register width (≥2)
- `CW`, `$clog2(W+1)`, width of `len` (≥ `$clog2(W+1)`)
- `TAPS`, `8'hB8`, W-bit LFSR tap mask (bit i set ⇒ `sh[i]` feeds back)
- `n_clk`  in  1  clock; all flops update on the falling edge of `n_clk`
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  playback request, sampled only in IDLE
- `pat`  in  W  pattern (shift mode) or seed (LFSR mode), captured with `start`
- `len`  in  CW  number of bits to emit
- `lfsr`  in  1  mode select captured with `start`: 0 = shift, 1 = LFSR
- `stop`  in  1  synchronous abort, effective in RUN
- `a`  out  1  registered serial bit to `c4`
- `busy`  out  1  high while bits are being emitted (RUN)
- `done`  out  1  one-cycle pulse after a completed run

## Operation
- **State register:** IDLE, RUN, DONE.
- **Internal registers:**
  - `sh[W-1:0]`: shift/LFSR register.
  - `cnt[CW-1:0]`: bits remaining.
  - `m`: captured mode.
- **IDLE:** `a`=0, `busy`=0, `done`=0.
  - `start`=1 captures `pat` into `sh`, `lfsr` into `m`, and the effective length into `cnt`.
  - Shift mode: effective length is `len`, clamped to W if `len` > W.
  - LFSR mode: effective length is `len` unclamped.
  - If the effective length is 0, go to DONE.
  - Otherwise go to RUN, with `a` ← `pat[W-1]`, `busy` ← 1, `cnt` ← effective length − 1.
  - In LFSR mode, a captured seed of all zeros is replaced by 1 (`sh` ← `{{W-1{0}},1}`). The first `a` is then 0.
- **RUN:** each edge with `cnt` ≠ 0:
  - Shift mode: `sh` ← `{sh[W-2:0],1'b0}`.
  - LFSR mode: `sh` ← `{sh[W-2:0], ^(sh & TAPS)}`.
  - Then `a` ← new `sh[W-1]` and `cnt` ← `cnt` − 1.
  - When `cnt` = 0: go to DONE, with `a` ← 0, `busy` ← 0, `done` ← 1.
- **DONE:** `done` stays high for exactly one cycle. The next edge goes to IDLE with `done` ← 0.
- **`stop`:**
  - `stop`=1 in RUN goes to IDLE on the next edge, with `a` ← 0 and `busy` ← 0; `done` is not pulsed.
  - `stop` has priority over the `cnt`=0 completion.
  - `stop` is ignored in IDLE and DONE.
- **`start` handling:**
  - `start` is ignored in RUN and DONE; there is no queuing.
  - A `start` held high through DONE is taken on the first IDLE edge, giving a back-to-back run one cycle after `done`.
- `pat`, `len` and `lfsr` are don't-care except on the capture edge.

## Timing
- **Reset values:** `rst`=1 immediately (asynchronously) forces state IDLE, `a`=0, `busy`=0, `done`=0, `sh`=0, `cnt`=0, `m`=0. This holds mid-run; no `done` follows.
- **Start latency:** `start` sampled at falling edge k ⇒ the first bit is valid on `a` from edge k to edge k+1.
- **Bit timing:** bit i (0-based) is valid on `a` from edge k+i to edge k+i+1.
- **`busy`:** high from edge k to edge k+N, where N is the effective length.
- **`done`:** high from edge k+N to edge k+N+1. IDLE is re-entered at edge k+N+1.
- **N = 0:** `done` is high from edge k to edge k+1, `busy` is never high, and `a` stays 0.
- All outputs are registered, so `a` is stable around the `c4` sampling edge.

## Test plan
- **Shift run:** W=8, `pat`=8'b1011_0010, `len`=8, `lfsr`=0, one-cycle `start` → `a` = 1,0,1,1,0,0,1,0 on 8 successive edges; `busy` high 8 cycles; `done` 1 cycle; then `a`=0.
- **Short run and zero length:** `pat`=8'hA0, `len`=3 → `a` = 1,0,1, then `done`. `len`=0 → `done` high the cycle after the start edge, `busy` never high, `a`=0 throughout.
- **Clamp:** shift mode, `len`=12 (CW=4 for this case), `pat`=8'hFF → exactly 8 ones, then `done`.
- **LFSR run:** `lfsr`=1, `pat`=8'h80, `TAPS`=8'hB8, `len`=10 → `a` = 1,0,0,0,0,0,0,0,1,0; `sh` after the final shift = 8'h1C.
- **Aborts and ignored start:**
  - `stop` on the 3rd RUN cycle of an 8-bit run → `a`=0 and `busy`=0 next edge, no `done`.
  - A `start` pulse during RUN is ignored: the run length is unchanged.
- **Reset and back-to-back:**
  - `rst` pulse mid-run → `a`, `busy`, `done` go to 0 immediately.
  - With `start` held high, a new run begins one cycle after the `done` pulse.
